// File: rtl/expr_tx_if.sv
// Character stream channel between the expression transmitter and its consumer.
// Carries one ASCII character per valid/ready handshake.
interface expr_tx_if;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output out,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/expr_tx.sv
// Expression stream transmitter: serialises a latched list of decimal operands
// and +/* operators as ASCII "d(op d)*", one character per accepted handshake.
module expr_tx #(
  parameter int unsigned MAX_TERMS = 4,
  parameter int unsigned TW        = $clog2(MAX_TERMS + 1)
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   start,
  input  logic [TW-1:0]          terms,
  input  logic [4*MAX_TERMS-1:0] digits,
  input  logic [MAX_TERMS-2:0]   ops,
  expr_tx_if.master              tx,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  typedef enum logic [1:0] {
    IDLE,
    DIGIT,
    OP,
    DONE
  } state_t;

  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;

  state_t                 state;
  logic [TW-1:0]          idx;
  logic [TW-1:0]          terms_q;
  logic [4*MAX_TERMS-1:0] digits_q;
  logic [MAX_TERMS-2:0]   ops_q;

  logic                   legal;
  logic [3:0]             dig_next;
  logic                   op_cur;
  logic                   is_last;

  // Only digits below the requested operand count take part in the check.
  always_comb begin
    legal = 1'b1;
    if (terms == '0 || terms > TW'(MAX_TERMS))
      legal = 1'b0;
    for (int unsigned k = 0; k < MAX_TERMS; k++) begin
      if (TW'(k) < terms && digits[4*k +: 4] > 4'd9)
        legal = 1'b0;
    end
  end

  always_comb begin
    dig_next = '0;
    for (int unsigned k = 0; k < MAX_TERMS; k++) begin
      if (TW'(k) == idx + TW'(1))
        dig_next = digits_q[4*k +: 4];
    end
  end

  always_comb begin
    op_cur = 1'b0;
    for (int unsigned k = 0; k < MAX_TERMS - 1; k++) begin
      if (TW'(k) == idx)
        op_cur = ops_q[k];
    end
  end

  assign is_last = (idx == terms_q - TW'(1));

  // Outputs are registered alongside the state so that each one already
  // reflects the state being entered, giving Moore behaviour with no decode.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state        <= IDLE;
      idx          <= '0;
      terms_q      <= '0;
      digits_q     <= '0;
      ops_q        <= '0;
      tx.out       <= '0;
      tx.out_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (legal) begin
              terms_q      <= terms;
              digits_q     <= digits;
              ops_q        <= ops;
              idx          <= '0;
              state        <= DIGIT;
              tx.out       <= CH_ZERO + {4'h0, digits[3:0]};
              tx.out_valid <= 1'b1;
              busy         <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end

        DIGIT: begin
          if (tx.out_ready) begin
            if (is_last) begin
              state        <= DONE;
              tx.out       <= '0;
              tx.out_valid <= 1'b0;
              done         <= 1'b1;
            end else begin
              state  <= OP;
              tx.out <= op_cur ? CH_MUL : CH_PLUS;
            end
          end
        end

        OP: begin
          if (tx.out_ready) begin
            idx    <= idx + TW'(1);
            state  <= DIGIT;
            tx.out <= CH_ZERO + {4'h0, dig_next};
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state        <= IDLE;
          tx.out       <= '0;
          tx.out_valid <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_expr_tx.sv
// Randomised self-checking bench for expr_tx against a character-queue model
// built directly from the operand/operator lists.
module tb_expr_tx;
  localparam int MAXT = 4;
  localparam int TWB  = 3;

  logic              clk;
  logic              clr_n;
  logic              start;
  logic [TWB-1:0]    terms;
  logic [4*MAXT-1:0] digits;
  logic [MAXT-2:0]   ops;
  logic              busy;
  logic              done;
  logic              err;

  int total;
  int bad;

  expr_tx_if bus ();

  expr_tx #(.MAX_TERMS(MAXT)) dut (
    .clk    (clk),
    .clr_n  (clr_n),
    .start  (start),
    .terms  (terms),
    .digits (digits),
    .ops    (ops),
    .tx     (bus),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rand_digits_nib(input int k, input int t);
    if (k < t) return 4'($urandom_range(0, 9));
    return 4'($urandom_range(0, 15));
  endfunction

  // mode 0: ready held high; 1: random ready; 2: random ready plus input disturbance
  task automatic run_expr(input int t, input logic [15:0] d, input logic [2:0] o, input int mode);
    logic [7:0] q[$];
    int cyc;
    int guard;
    logic rdy;
    q = {};
    for (int k = 0; k < t; k++) begin
      q.push_back(8'h30 + {4'h0, d[4*k +: 4]});
      if (k < t - 1) q.push_back(o[k] ? 8'h2A : 8'h2B);
    end
    terms = TWB'(t);
    digits = d;
    ops = o;
    start = 1'b1;
    bus.out_ready = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    guard = 0;
    while (q.size() > 0 && guard < 200) begin
      check("valid", 32'(bus.out_valid), 32'd1);
      check("char", 32'(bus.out), 32'(q[0]));
      check("busy_mid", 32'(busy), 32'd1);
      check("done_early", 32'(done), 32'd0);
      rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.out_ready = rdy;
      if (mode == 2) begin
        start  = 1'($urandom_range(0, 1));
        digits = 16'($urandom);
        ops    = 3'($urandom);
        terms  = 3'($urandom);
      end
      step();
      if (rdy) void'(q.pop_front());
      cyc++;
      guard++;
    end
    if (guard >= 200) check("stream_timeout", 32'd1, 32'd0);
    start = 1'b0;
    bus.out_ready = 1'($urandom_range(0, 1));
    check("done_pulse", 32'(done), 32'd1);
    check("valid_done", 32'(bus.out_valid), 32'd0);
    check("out_done", 32'(bus.out), 32'd0);
    check("busy_done", 32'(busy), 32'd1);
    if (mode == 0) check("done_latency", 32'(cyc), 32'(2 * t));
    step();
    check("done_clear", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("valid_idle", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic run_illegal(input logic [2:0] t, input logic [15:0] d);
    terms = t;
    digits = d;
    ops = 3'($urandom);
    start = 1'b1;
    step();
    start = 1'b0;
    check("err_pulse", 32'(err), 32'd1);
    check("err_valid", 32'(bus.out_valid), 32'd0);
    check("err_busy", 32'(busy), 32'd0);
    step();
    check("err_clear", 32'(err), 32'd0);
    check("err_valid2", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] d;
    int t;
    total = 0;
    bad = 0;
    clr_n = 1'b0;
    start = 1'b0;
    terms = '0;
    digits = '0;
    ops = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    clr_n = 1'b1;
    step();

    run_expr(3, 16'hF321, 3'b010, 0);
    run_expr(3, 16'hF321, 3'b010, 1);
    run_expr(1, 16'hFFF9, 3'b000, 0);
    run_expr(4, 16'h9876, 3'b111, 0);

    run_illegal(3'd0, 16'h0000);
    run_illegal(3'd5, 16'h1111);
    run_illegal(3'd7, 16'h1111);
    run_illegal(3'd2, 16'h00A0);
    run_illegal(3'd4, 16'hB000);

    for (int n = 0; n < 30; n++) begin
      t = $urandom_range(1, MAXT);
      for (int k = 0; k < MAXT; k++) d[4*k +: 4] = rand_digits_nib(k, t);
      run_expr(t, d, 3'($urandom), n % 3);
    end

    // Abort while the first operator is on the bus.
    terms = 3'd3;
    digits = 16'h0456;
    ops = 3'b001;
    bus.out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("pre_abort_op", 32'(bus.out), 32'h2A);
    clr_n = 1'b0;
    #1;
    check("abort_out", 32'(bus.out), 32'd0);
    check("abort_valid", 32'(bus.out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    step();
    clr_n = 1'b1;
    step();
    check("post_abort_done", 32'(done), 32'd0);
    check("post_abort_valid", 32'(bus.out_valid), 32'd0);
    run_expr(2, 16'hFF85, 3'b000, 1);
    run_expr(4, 16'h0000, 3'b101, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
